// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the data-bus responder.
// No logic; no latency or backpressure.
package mem_bus_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;
    localparam int          WORD_BYTES       = 4;

    // Index width for a power-of-two depth; never below 1 bit.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        if (r < 1) r = 1;
        return r;
    endfunction

endpackage

// File: rtl/data_mem_responder_sp_ram.sv
// Single-port synchronous RAM, 32-bit words, read data registered and not reset.
// Latency 1 on reads; o_rdata only changes on a read, so it holds across writes.
// No backpressure: one access per cycle when i_en is high.
module sp_ram
    import mem_bus_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = clog2(DEPTH_WORDS)
) (
    input  logic          i_clk,
    input  logic          i_en,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];

    always_ff @(posedge i_clk) begin
        if (i_en) begin
            if (i_we) begin
                r_mem[i_addr] <= i_wdata;
            end else begin
                o_rdata <= r_mem[i_addr];
            end
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-bus responder: window decode, one posted write, forwarding to reads (ACCESS_CNT_EN adds counters).
// Read data latency 1; BUS_ERR one cycle after a bad access.
// No backpressure: writes are posted, reads win the RAM port and commits wait.
module data_mem_responder
    import mem_bus_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
    parameter int          DEPTH_WORDS = 256,
    parameter logic [31:0] ERR_DATA    = ERR_DATA_DEFAULT
) (
    input  logic        CLK,
    input  logic        Rst,
    input  logic        CS,
    input  logic        WR_RD,
    input  logic [31:0] ADDR,
    input  logic [31:0] Data_BUS_WRITE,
    output logic [31:0] Data_BUS_READ,
    output logic        BUS_ERR
`ifdef ACCESS_CNT_EN
    ,
    output logic [15:0] RD_CNT,
    output logic [15:0] WR_CNT
`endif
);

    localparam int          IDXW      = clog2(DEPTH_WORDS);
    localparam logic [31:0] WIN_BYTES = 32'(DEPTH_WORDS * WORD_BYTES);

    logic [31:0]     w_off;
    logic            w_hit;
    logic            w_miss;
    logic            w_rd;
    logic            w_rd_hit;
    logic            w_wr_hit;
    logic [IDXW-1:0] w_idx;
    logic            w_same_idx;
    state_t          r_state;
    state_t          w_state_nxt;
    logic [IDXW-1:0] r_pend_idx;
    logic [31:0]     r_pend_dat;
    logic            w_ram_en;
    logic            w_ram_we;
    logic [IDXW-1:0] w_ram_addr;
    logic [31:0]     w_ram_rdata;
    logic            r_rd_from_ram;
    logic [31:0]     r_rd_dat;
    logic            r_bus_err;

    assign w_off      = ADDR - ADDR_BASE;
    assign w_hit      = CS && (ADDR[1:0] == 2'b00) && (w_off < WIN_BYTES);
    assign w_miss     = CS && !w_hit;
    assign w_rd       = CS && !WR_RD;
    assign w_rd_hit   = w_hit && !WR_RD;
    assign w_wr_hit   = w_hit && WR_RD;
    assign w_idx      = w_off[IDXW+1:2];
    assign w_same_idx = (r_state == PEND) && (w_idx == r_pend_idx);

    always_comb begin
        w_state_nxt = r_state;
        w_ram_en    = 1'b0;
        w_ram_we    = 1'b0;
        w_ram_addr  = w_idx;
        // Any read (even a miss) occupies the port; a same-index rewrite just replaces the entry.
        if (w_rd_hit) begin
            w_ram_en = 1'b1;
        end else if (r_state == PEND && !w_rd && !(w_wr_hit && w_same_idx)) begin
            w_ram_en   = 1'b1;
            w_ram_we   = 1'b1;
            w_ram_addr = r_pend_idx;
        end
        case (r_state)
            IDLE:    if (w_wr_hit) w_state_nxt = PEND;
            PEND:    if (!w_wr_hit && !w_rd) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        if (Rst) begin
            w_ram_en = 1'b0;
            w_ram_we = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (Rst) begin
            r_state       <= IDLE;
            r_pend_idx    <= '0;
            r_pend_dat    <= '0;
            r_rd_from_ram <= 1'b0;
            r_rd_dat      <= '0;
            r_bus_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_bus_err <= w_miss;
            if (w_wr_hit) begin
                r_pend_idx <= w_idx;
                r_pend_dat <= Data_BUS_WRITE;
            end
            if (w_rd) begin
                if (w_rd_hit && !w_same_idx) begin
                    r_rd_from_ram <= 1'b1;
                end else begin
                    r_rd_from_ram <= 1'b0;
                    r_rd_dat      <= w_rd_hit ? r_pend_dat : ERR_DATA;
                end
            end
        end
    end

    sp_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (IDXW)
    ) u_ram (
        .i_clk   (CLK),
        .i_en    (w_ram_en),
        .i_we    (w_ram_we),
        .i_addr  (w_ram_addr),
        .i_wdata (r_pend_dat),
        .o_rdata (w_ram_rdata)
    );

    assign Data_BUS_READ = r_rd_from_ram ? w_ram_rdata : r_rd_dat;
    assign BUS_ERR       = r_bus_err;

`ifdef ACCESS_CNT_EN
    logic [15:0] r_rd_cnt;
    logic [15:0] r_wr_cnt;

    always_ff @(posedge CLK) begin
        if (Rst) begin
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
        end else begin
            if (w_rd_hit && r_rd_cnt != 16'hFFFF) r_rd_cnt <= r_rd_cnt + 16'd1;
            if (w_wr_hit && r_wr_cnt != 16'hFFFF) r_wr_cnt <= r_wr_cnt + 16'd1;
        end
    end

    assign RD_CNT = r_rd_cnt;
    assign WR_CNT = r_wr_cnt;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: posted writes, forwarding, errors, reset discard, counters.
module tb_data_mem_responder;

    logic        CLK = 1'b0;
    logic        Rst;
    logic        CS;
    logic        WR_RD;
    logic [31:0] ADDR;
    logic [31:0] Data_BUS_WRITE;
    logic [31:0] Data_BUS_READ;
    logic        BUS_ERR;
`ifdef ACCESS_CNT_EN
    logic [15:0] RD_CNT;
    logic [15:0] WR_CNT;
`endif

    int n_pass  = 0;
    int n_total = 0;

    data_mem_responder #(
        .ADDR_BASE   (32'h0000_0000),
        .DEPTH_WORDS (256),
        .ERR_DATA    (32'hDEAD_BEEF)
    ) dut (
        .CLK            (CLK),
        .Rst            (Rst),
        .CS             (CS),
        .WR_RD          (WR_RD),
        .ADDR           (ADDR),
        .Data_BUS_WRITE (Data_BUS_WRITE),
        .Data_BUS_READ  (Data_BUS_READ),
        .BUS_ERR        (BUS_ERR)
`ifdef ACCESS_CNT_EN
        ,
        .RD_CNT         (RD_CNT),
        .WR_CNT         (WR_CNT)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic step(input logic rst, input logic cs, input logic wr,
                        input logic [31:0] a, input logic [31:0] d);
        Rst            = rst;
        CS             = cs;
        WR_RD          = wr;
        ADDR           = a;
        Data_BUS_WRITE = d;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 32'h0000_0402, 32'h0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        step(1'b0, 1'b1, 1'b1, a, d);
    endtask

    task automatic rd(input logic [31:0] a);
        step(1'b0, 1'b1, 1'b0, a, 32'h0);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    initial begin
        Rst = 1'b1; CS = 1'b0; WR_RD = 1'b0; ADDR = '0; Data_BUS_WRITE = '0;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        idle();
        check("rst_rdata", Data_BUS_READ, 32'h0);
        check("rst_err", {31'b0, BUS_ERR}, 32'h0);
        for (int i = 0; i < 5; i++) begin
            idle();
            check("idle_rdata", Data_BUS_READ, 32'h0);
            check("idle_err", {31'b0, BUS_ERR}, 32'h0);
        end

        // Known background contents, committed via idle cycles.
        wr(32'h0, 32'h0000_A5A5); idle();
        wr(32'h30, 32'h0000_1234); idle();

        wr(32'h10, 32'h0000_1DAA);
        rd(32'h10);
        check("fwd_read", Data_BUS_READ, 32'h0000_1DAA);
        check("fwd_err", {31'b0, BUS_ERR}, 32'h0);
        idle();
        check("hold_rdata", Data_BUS_READ, 32'h0000_1DAA);
        rd(32'h10);
        check("ram_read_10", Data_BUS_READ, 32'h0000_1DAA);

        wr(32'h20, 32'h0000_1111);
        wr(32'h20, 32'h0000_2222);
        rd(32'h20);
        check("overwrite_fwd", Data_BUS_READ, 32'h0000_2222);
        idle();
        rd(32'h20);
        check("overwrite_ram", Data_BUS_READ, 32'h0000_2222);

        rd(32'h10);
        check("rd_before_wr", Data_BUS_READ, 32'h0000_1DAA);
        wr(32'h10, 32'h0000_5555);
        rd(32'h10);
        check("rd_after_wr", Data_BUS_READ, 32'h0000_5555);
        idle();

        rd(32'h402);
        check("misalign_data", Data_BUS_READ, 32'hDEAD_BEEF);
        check("misalign_err", {31'b0, BUS_ERR}, 32'h1);
        idle();
        check("err_pulse_end", {31'b0, BUS_ERR}, 32'h0);
        check("err_data_hold", Data_BUS_READ, 32'hDEAD_BEEF);
        wr(32'h400, 32'h0000_0BAD);
        check("oow_write_err", {31'b0, BUS_ERR}, 32'h1);
        rd(32'h0);
        check("after_err_read0", Data_BUS_READ, 32'h0000_A5A5);
        check("after_err_noerr", {31'b0, BUS_ERR}, 32'h0);
        rd(32'h1000);
        check("consec_err_1", {31'b0, BUS_ERR}, 32'h1);
        wr(32'h401, 32'h0);
        check("consec_err_2", {31'b0, BUS_ERR}, 32'h1);
        idle();
        check("consec_err_end", {31'b0, BUS_ERR}, 32'h0);

        wr(32'h3FC, 32'h0000_0077);
        rd(32'h3FC);
        check("top_word_fwd", Data_BUS_READ, 32'h0000_0077);
        check("top_word_noerr", {31'b0, BUS_ERR}, 32'h0);
        idle();
        rd(32'h3FC);
        check("top_word_ram", Data_BUS_READ, 32'h0000_0077);

        // A read miss keeps the entry pending; an errored write then commits it.
        wr(32'h40, 32'h0000_4444);
        rd(32'h401);
        check("pend_miss_data", Data_BUS_READ, 32'hDEAD_BEEF);
        rd(32'h40);
        check("pend_after_miss", Data_BUS_READ, 32'h0000_4444);
        wr(32'h800, 32'h0);
        rd(32'h40);
        check("errwr_commit", Data_BUS_READ, 32'h0000_4444);

        wr(32'h30, 32'h0000_CAFE);
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        check("midrst_rdata", Data_BUS_READ, 32'h0);
        rd(32'h30);
        check("midrst_discard", Data_BUS_READ, 32'h0000_1234);

`ifdef ACCESS_CNT_EN
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        check("cnt_rst_rd", {16'b0, RD_CNT}, 32'h0);
        check("cnt_rst_wr", {16'b0, WR_CNT}, 32'h0);
        rd(32'h0); rd(32'h10); rd(32'h20);
        wr(32'h50, 32'h1); wr(32'h54, 32'h2);
        rd(32'h403);
        idle();
        check("cnt_rd3", {16'b0, RD_CNT}, 32'd3);
        check("cnt_wr2", {16'b0, WR_CNT}, 32'd2);
        for (int i = 0; i < 70000; i++) rd(32'h0);
        check("cnt_rd_sat", {16'b0, RD_CNT}, 32'h0000_FFFF);
        check("cnt_wr_hold", {16'b0, WR_CNT}, 32'd2);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Bus responder (data memory) for the CPU's data bus, i.e. the target end of the CS / WR_RD / ADDR / Data_BUS_WRITE / Data_BUS_READ interface.
- Decodes a word-aligned address window and holds one posted write in a holding register.
- Commits that write to a single-port synchronous RAM when the port is free.
- Returns registered read data, with forwarding from the posted write.
- Sits between the CPU bus pins and the RAM; replaces the constant read-data stub currently used in the CPU bench.

Parameters:
- ADDR_BASE, 32'h0000_0000: byte address of word 0 of the window.
- DEPTH_WORDS, 256: number of 32-bit words (power of two).
- ERR_DATA, 32'hDEAD_BEEF: value returned on an errored read.

Ports:
- CLK  in  1: system clock; all logic on the rising edge.
- Rst  in  1: synchronous, active-high reset.
- CS  in  1: bus access strobe; one access per cycle while high.
- WR_RD  in  1: 1 = write, 0 = read; sampled only when CS=1.
- ADDR  in  32: byte address.
- Data_BUS_WRITE  in  32: write data.
- Data_BUS_READ  out  32: registered read data.
- BUS_ERR  out  1: one-cycle pulse for an out-of-window or misaligned access.

Behaviour:
- Reset (Rst=1 at an edge):
  - Data_BUS_READ=0, BUS_ERR=0, FSM=IDLE.
  - A pending posted write is discarded, never committed; this applies to a reset mid-operation.
  - RAM contents are not reset.
- Decode:
  - hit = CS & ADDR[1:0]==0 & ADDR-ADDR_BASE < DEPTH_WORDS*4.
  - Word index = (ADDR-ADDR_BASE)>>2, width log2(DEPTH_WORDS).
  - A miss with CS=1 means no RAM or buffer effect, and BUS_ERR=1 in the next cycle.
- Read (CS=1, WR_RD=0):
  - Data_BUS_READ updates at the edge one cycle after the request (latency 1).
  - On a hit, the value is the posted-write data if state=PEND and the index matches, else RAM[index].
  - On a miss, the value is ERR_DATA.
  - Data_BUS_READ holds its value in all non-read cycles.
- FSM states:
  - IDLE: no posted write.
  - PEND: holding register {idx, data} valid.
- FSM transitions:
  - IDLE + write hit → PEND; capture idx/data.
  - PEND + write hit → commit the held entry to RAM this cycle; capture the new entry; stay PEND.
  - PEND + write hit, same index → commit skipped; new data overwrites the held entry (last write wins).
  - PEND + read (hit or miss) → RAM port busy with the read; stay PEND.
  - PEND + idle cycle or errored write → commit the held entry; go to IDLE.
  - IDLE + read, idle or errored access → stay IDLE.
- RAM port usage:
  - At most one RAM access per cycle; a read has priority over a commit.
  - Occupancy never exceeds one entry, and no write is ever dropped or stalled; the bus has no wait signal.
- Back-to-back accesses:
  - Write then read of the same address returns the new data via forwarding.
  - Read then write of the same address: the read returns the old data.
- BUS_ERR:
  - Registered: asserted in the cycle after the errored access, for exactly one cycle per errored access.
  - Consecutive errored accesses keep it high.

Optional Feature:
- Macro ACCESS_CNT_EN.
- Defined:
  - Adds outputs RD_CNT[15:0] and WR_CNT[15:0].
  - These are saturating counts of read hits and write hits; errored accesses are not counted.
  - Both reset to 0 on Rst and hold at 16'hFFFF.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package mem_bus_pkg:
  - state enum {IDLE, PEND}.
  - Constants ERR_DATA_DEFAULT and WORD_BYTES=4.
  - Function clog2 for the index width.
- Sub-module sp_ram:
  - Single-port synchronous RAM, DEPTH_WORDS x 32, inputs en/we/addr/wdata, output rdata.
  - rdata is registered, latency 1, and not reset.
  - data_mem_responder muxes forwarding and ERR_DATA after rdata.

Test Plan:
- Reset check: Rst=1 for 3 cycles, then 0 → Data_BUS_READ=0, BUS_ERR=0, state IDLE; an idle bus for 5 cycles keeps both at 0.
- Write then forward: write 0x10 ← 0x1DAA, then read 0x10 next cycle → Data_BUS_READ=0x1DAA one cycle later. An idle cycle plus another read of 0x10 → 0x1DAA from RAM.
- Same-index overwrite: write 0x20←0x1111, write 0x20←0x2222, read 0x20 → 0x2222. After idle, reading 0x20 from RAM → 0x2222.
- Errors: read 0x402 (misaligned) → ERR_DATA and BUS_ERR pulse one cycle later. Write to 0x400 with DEPTH_WORDS=256 → BUS_ERR pulse; a later read of 0x0 is unaffected.
- Reset mid-operation: write 0x30←0xCAFE, assert Rst the next cycle, then read 0x30 → the pre-existing RAM value, not 0xCAFE.
- ACCESS_CNT_EN: 3 read hits, 2 write hits and 1 miss → RD_CNT=3, WR_CNT=2. Force 70000 reads → RD_CNT=16'hFFFF.
